// File: rtl/hamming_dec_pkg.sv
// Shared constants, FSM state type and Hamming(7,4) syndrome helper for the
// serial frame decoder. Codewords are held MSB-first as received, so c1 sits
// in bit [6] and c7 in bit [0].
package hamming_dec_pkg;

    localparam int CW_LEN       = 7;
    localparam int DATA_LEN     = 4;
    localparam int CW_PER_FRAME = 8;
    localparam int WORD_W       = DATA_LEN * CW_PER_FRAME;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    // Syndrome {s3,s2,s1}; a nonzero value names the 1-based bit position in error.
    function automatic logic [2:0] hamming_syndrome(input logic [CW_LEN-1:0] cw);
        logic s1;
        logic s2;
        logic s3;
        s1 = cw[6] ^ cw[4] ^ cw[2] ^ cw[0];
        s2 = cw[5] ^ cw[4] ^ cw[1] ^ cw[0];
        s3 = cw[3] ^ cw[2] ^ cw[1] ^ cw[0];
        return {s3, s2, s1};
    endfunction

endpackage

// File: rtl/hamming74_correct.sv
// Combinational Hamming(7,4) single-error corrector. Only data positions
// (c3, c5, c6, c7) matter for the nibble, so a syndrome pointing at a parity
// bit leaves the data untouched but still reports a correction.
module hamming74_correct
    import hamming_dec_pkg::*;
(
    input  logic [CW_LEN-1:0]   i_codeword,
    output logic [DATA_LEN-1:0] o_nibble,
    output logic [2:0]          o_syndrome,
    output logic                o_corrected
);

    logic [2:0]          w_syn;
    logic [DATA_LEN-1:0] w_data_flip;

    // Compute syndrome and the data-bit flip mask it implies.
    always_comb begin
        w_syn       = hamming_syndrome(i_codeword);
        w_data_flip = 4'b0000;
        case (w_syn)
            3'd3:    w_data_flip = 4'b1000;
            3'd5:    w_data_flip = 4'b0100;
            3'd6:    w_data_flip = 4'b0010;
            3'd7:    w_data_flip = 4'b0001;
            default: w_data_flip = 4'b0000;
        endcase
    end

    assign o_nibble    = {i_codeword[4], i_codeword[2], i_codeword[1], i_codeword[0]} ^ w_data_flip;
    assign o_syndrome  = w_syn;
    assign o_corrected = (w_syn != 3'b000);

endmodule

// File: rtl/hamming_frame_decoder.sv
// Serial Hamming(7,4) frame decoder: deserializes 8 codewords after frame
// lock, corrects single-bit errors and presents one 32-bit word per frame on
// a valid/ready interface with correction, abort and overflow status.
// Optional build macro HDEC_ERR_MASK_EN adds data_out_err_mask, flagging which
// codewords of the word needed correction (codeword 0 -> bit 7).
module hamming_frame_decoder
    import hamming_dec_pkg::*;
#(
    parameter int CNT_W        = 16,
    parameter int CW_PER_FRAME = 8
)(
    input  logic             clk_out,
    input  logic             rst,
    input  logic             data_in,
    input  logic             frame_start,
    input  logic             is_frame_sychronized,
    output logic [31:0]      data_out,
    output logic             data_out_valid,
    input  logic             data_out_ready,
    output logic [CNT_W-1:0] corrected_cnt,
    output logic [CNT_W-1:0] abort_cnt,
    output logic             overflow
`ifdef HDEC_ERR_MASK_EN
    ,
    output logic [7:0]       data_out_err_mask
`endif
);

    state_t              r_state;
    state_t              w_next_state;

    logic [5:0]          r_shift;
    logic [2:0]          r_bit_cnt;
    logic [2:0]          r_cw_cnt;
    logic [27:0]         r_pack;

    logic [31:0]         r_data_out;
    logic                r_valid;
    logic [CNT_W-1:0]    r_corrected_cnt;
    logic [CNT_W-1:0]    r_abort_cnt;
    logic                r_overflow;

    logic                w_restart;
    logic                w_shift;
    logic                w_cw_done;
    logic                w_word_done;
    logic                w_abort;
    logic                w_cw_err;
    logic                w_can_load;

    logic [CW_LEN-1:0]   w_codeword;
    logic [DATA_LEN-1:0] w_nibble;
    logic [2:0]          w_syndrome;
    logic                w_corrected;
    logic [WORD_W-1:0]   w_word;

    // The last bit of a codeword is decoded straight off the wire so the
    // nibble is ready on the same edge that samples it.
    assign w_codeword = {r_shift, data_in};
    assign w_word     = {r_pack, w_nibble};
    assign w_cw_err   = w_corrected & (w_syndrome != 3'b000);
    assign w_can_load = ~r_valid | data_out_ready;

    hamming74_correct u_correct (
        .i_codeword  (w_codeword),
        .o_nibble    (w_nibble),
        .o_syndrome  (w_syndrome),
        .o_corrected (w_corrected)
    );

    // FSM state register.
    always_ff @(posedge clk_out or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state: loss of lock wins over a restart, which wins over completion.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (frame_start && is_frame_sychronized) begin
                    w_next_state = COLLECT;
                end else begin
                    w_next_state = IDLE;
                end
            end
            COLLECT: begin
                if (!is_frame_sychronized) begin
                    w_next_state = IDLE;
                end else if (frame_start) begin
                    w_next_state = COLLECT;
                end else if ((r_bit_cnt == 3'(CW_LEN - 1)) && (r_cw_cnt == 3'(CW_PER_FRAME - 1))) begin
                    w_next_state = IDLE;
                end else begin
                    w_next_state = COLLECT;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // FSM outputs: datapath strobes for start, shift, decode, completion and abort.
    always_comb begin
        w_restart   = 1'b0;
        w_shift     = 1'b0;
        w_cw_done   = 1'b0;
        w_word_done = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            IDLE: begin
                if (frame_start && is_frame_sychronized) begin
                    w_restart = 1'b1;
                end else begin
                    w_restart = 1'b0;
                end
            end
            COLLECT: begin
                if (!is_frame_sychronized) begin
                    w_abort = 1'b1;
                end else if (frame_start) begin
                    w_restart = 1'b1;
                end else begin
                    w_shift = 1'b1;
                    if (r_bit_cnt == 3'(CW_LEN - 1)) begin
                        w_cw_done   = 1'b1;
                        w_word_done = (r_cw_cnt == 3'(CW_PER_FRAME - 1));
                    end else begin
                        w_cw_done   = 1'b0;
                        w_word_done = 1'b0;
                    end
                end
            end
            default: begin
                w_restart = 1'b0;
            end
        endcase
    end

    // Deserializer: bit 0 of a frame is captured on the start cycle itself.
    always_ff @(posedge clk_out or posedge rst) begin
        if (rst) begin
            r_shift   <= 6'b000000;
            r_bit_cnt <= 3'd0;
            r_cw_cnt  <= 3'd0;
        end else if (w_restart) begin
            r_shift   <= {5'b00000, data_in};
            r_bit_cnt <= 3'd1;
            r_cw_cnt  <= 3'd0;
        end else if (w_shift) begin
            r_shift <= {r_shift[4:0], data_in};
            if (w_cw_done) begin
                r_bit_cnt <= 3'd0;
                r_cw_cnt  <= r_cw_cnt + 3'd1;
            end else begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end
        end
    end

    // Pack register: nibbles 0..6 land MSB-first; nibble 7 goes straight to the output.
    always_ff @(posedge clk_out or posedge rst) begin
        if (rst) begin
            r_pack <= 28'h0000000;
        end else if (w_cw_done) begin
            for (int k = 0; k < CW_PER_FRAME - 1; k++) begin
                if (r_cw_cnt == 3'(k)) begin
                    r_pack[27 - 4*k -: 4] <= w_nibble;
                end
            end
        end
    end

    // Output word register with valid/ready handshake and drop-on-full overflow.
    always_ff @(posedge clk_out or posedge rst) begin
        if (rst) begin
            r_data_out <= 32'h00000000;
            r_valid    <= 1'b0;
            r_overflow <= 1'b0;
        end else if (w_word_done) begin
            if (w_can_load) begin
                r_data_out <= w_word;
                r_valid    <= 1'b1;
            end else begin
                r_overflow <= 1'b1;
            end
        end else if (r_valid && data_out_ready) begin
            r_valid <= 1'b0;
        end
    end

    // Saturating status counters; decoded-codeword counts survive a later abort.
    always_ff @(posedge clk_out or posedge rst) begin
        if (rst) begin
            r_corrected_cnt <= {CNT_W{1'b0}};
            r_abort_cnt     <= {CNT_W{1'b0}};
        end else begin
            if (w_cw_done && w_cw_err && (r_corrected_cnt != {CNT_W{1'b1}})) begin
                r_corrected_cnt <= r_corrected_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (w_abort && (r_abort_cnt != {CNT_W{1'b1}})) begin
                r_abort_cnt <= r_abort_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

`ifdef HDEC_ERR_MASK_EN
    logic [6:0] r_mask_acc;
    logic [7:0] r_err_mask;

    // Per-codeword correction flags gathered alongside the nibbles.
    always_ff @(posedge clk_out or posedge rst) begin
        if (rst) begin
            r_mask_acc <= 7'b0000000;
        end else if (w_cw_done) begin
            for (int k = 0; k < CW_PER_FRAME - 1; k++) begin
                if (r_cw_cnt == 3'(k)) begin
                    r_mask_acc[6 - k] <= w_cw_err;
                end
            end
        end
    end

    // Error mask follows the same load/hold/drop rules as the data word.
    always_ff @(posedge clk_out or posedge rst) begin
        if (rst) begin
            r_err_mask <= 8'h00;
        end else if (w_word_done && w_can_load) begin
            r_err_mask <= {r_mask_acc, w_cw_err};
        end
    end

    assign data_out_err_mask = r_err_mask;
`endif

    assign data_out       = r_data_out;
    assign data_out_valid = r_valid;
    assign corrected_cnt  = r_corrected_cnt;
    assign abort_cnt      = r_abort_cnt;
    assign overflow       = r_overflow;

endmodule
